multicycle_controller: RTL

Main sequencing FSM for the multicycle MIPS core. It drives the shared instruction/data memory port, instruction register, register file, ALU and PC-update muxes through the phases of each instruction. It replaces the single-cycle control decode with a Moore state machine plus a memory ready/request handshake. ALU control decoding (ALUOp/Funct to ALUControl) is internal.

---
 rtl/multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main sequencing FSM for the multicycle MIPS core. It steps each instruction
// through fetch, decode, execute, memory and writeback phases. It uses a
// request/ready handshake with the shared instruction/data memory. ALU control
// decoding from Funct is done internally.
//
// Ports:
//   clk, reset        core clock; asynchronous active-high reset (forces FETCH)
//   Op, Funct         instruction fields IR[31:26], IR[5:0]
//   Zero              ALU zero flag (combinational from the datapath)
//   MemReady          memory completes the current access this cycle
//   MemReq, IorD, MemWrite         memory port control
//   IRWrite, PCEn, PCSrc           instruction register / PC update control
//   ALUSrcA, ALUSrcB, ALUControl   ALU operand and operation select
//   RegDst, MemToReg, RegWrite     register file write control
//   Retired           one-cycle pulse on the last cycle of each instruction
//   Trap              high while parked in TRAP after an unsupported Op/Funct
//   State             current state code (debug)
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       Retired,
  output logic       Trap,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_TRAP    = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Returns {supported, alu_control} for an R-type Funct field.
  function automatic logic [3:0] alu_decode(input logic [5:0] funct);
    logic [3:0] res;
    case (funct)
      6'b100000: res = {1'b1, ALU_ADD};
      6'b100010: res = {1'b1, ALU_SUB};
      6'b100100: res = {1'b1, ALU_AND};
      6'b100101: res = {1'b1, ALU_OR};
      6'b101010: res = {1'b1, ALU_SLT};
      default:   res = {1'b0, 3'b000};
    endcase
    return res;
  endfunction

  logic [3:0] state_r;
  logic [3:0] next_s;
  logic [3:0] funct_dec_s;

  logic       memreq_s;
  logic       iord_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       pcwrite_s;
  logic       branch_s;
  logic [1:0] pcsrc_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [2:0] aluctl_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       regwrite_s;
  logic       retired_s;
  logic       trap_s;

  assign funct_dec_s = alu_decode(Funct);

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; unused codes 13-15 fall back to FETCH.
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (MemReady) next_s = S_DECODE;
        else          next_s = S_FETCH;
      end
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: next_s = S_MEMADR;
          OP_R:         next_s = S_EXECUTE;
          OP_BEQ:       next_s = S_BRANCH;
          OP_ADDI:      next_s = S_ADDIEX;
          OP_J:         next_s = S_JUMP;
          default:      next_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        // Op is held by the IR, so only lw/sw can reach here.
        if (Op == OP_SW)      next_s = S_MEMWR;
        else if (Op == OP_LW) next_s = S_MEMRD;
        else                  next_s = S_FETCH;
      end
      S_MEMRD: begin
        if (MemReady) next_s = S_MEMWB;
        else          next_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (MemReady) next_s = S_FETCH;
        else          next_s = S_MEMWR;
      end
      S_EXECUTE: begin
        if (funct_dec_s[3]) next_s = S_ALUWB;
        else                next_s = S_TRAP;
      end
      S_ADDIEX: next_s = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: next_s = S_FETCH;
      S_TRAP:   next_s = S_TRAP;
      default:  next_s = S_FETCH;
    endcase
  end

  // Per-state control decode; everything not driven in a state stays 0.
  always_comb begin
    memreq_s   = 1'b0;
    iord_s     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    pcsrc_s    = 2'b00;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    aluctl_s   = 3'b000;
    regdst_s   = 1'b0;
    memtoreg_s = 1'b0;
    regwrite_s = 1'b0;
    retired_s  = 1'b0;
    trap_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but committed only on completion.
        memreq_s  = 1'b1;
        irwrite_s = MemReady;
        pcwrite_s = MemReady;
        alusrcb_s = 2'b01;
        aluctl_s  = ALU_ADD;
      end
      S_DECODE: begin
        alusrcb_s = 2'b11;
        aluctl_s  = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        aluctl_s  = ALU_ADD;
      end
      S_MEMRD: begin
        memreq_s = 1'b1;
        iord_s   = 1'b1;
      end
      S_MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
        retired_s  = 1'b1;
      end
      S_MEMWR: begin
        memreq_s   = 1'b1;
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
        retired_s  = MemReady;
      end
      S_EXECUTE: begin
        alusrca_s = 1'b1;
        aluctl_s  = funct_dec_s[2:0];
      end
      S_ALUWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
        retired_s  = 1'b1;
      end
      S_BRANCH: begin
        alusrca_s = 1'b1;
        aluctl_s  = ALU_SUB;
        branch_s  = 1'b1;
        pcsrc_s   = 2'b01;
        retired_s = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
        retired_s  = 1'b1;
      end
      S_JUMP: begin
        pcsrc_s   = 2'b10;
        pcwrite_s = 1'b1;
        retired_s = 1'b1;
      end
      S_TRAP: begin
        trap_s = 1'b1;
      end
      default: begin
        trap_s = 1'b0;
      end
    endcase
  end

  // Enables and strobes are forced low while reset is held. State already
  // sits at FETCH then, but FETCH would otherwise request memory.
  assign MemReq     = memreq_s & ~reset;
  assign MemWrite   = memwrite_s & ~reset;
  assign IRWrite    = irwrite_s & ~reset;
  assign PCEn       = (pcwrite_s | (branch_s & Zero)) & ~reset;
  assign RegWrite   = regwrite_s & ~reset;
  assign Retired    = retired_s & ~reset;
  assign Trap       = trap_s & ~reset;
  assign IorD       = iord_s;
  assign PCSrc      = pcsrc_s;
  assign ALUSrcA    = alusrca_s;
  assign ALUSrcB    = alusrcb_s;
  assign ALUControl = aluctl_s;
  assign RegDst     = regdst_s;
  assign MemToReg   = memtoreg_s;
  assign State      = state_r;

endmodule
